convergence_check_block: RTL and testbench
==========================================

Name: convergence_check_block

Overview:
- Sits directly downstream of the new-means calculation stage.
- Consumes one 91-bit new centroid per cycle, plus its divide_by_0 flag, for each of the 8 clusters.
- Compares each new centroid against the stored previous centroid and writes it back to an internal centroid bank, except for empty clusters.
- At round end, reports to the controller whether all clusters moved no more than a threshold (L1 distance), and tracks the iteration count.

Parameters:
- dataWidth, 91, packed centroid width (7 coordinates).
- cordinate_width, 13, signed two's-complement coordinate width; coordinate k occupies bits [13k+12:13k], k=0..6.
- centroid_num, 8, number of clusters per round.
- dist_width, 17, width of per-centroid L1 distance and of threshold.
- iter_width, 8, iteration counter width.
- max_iter, 100, iteration limit.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- init_wr_en  in  1  bank initial-load strobe; honoured only in IDLE
- init_addr  in  3  bank index for initial load
- init_data  in  91  initial centroid value
- start  in  1  begin round; honoured only in IDLE
- new_valid  in  1  new_centroid/divide_by_0 valid this cycle
- new_centroid  in  91  new centroid from the means stage
- divide_by_0  in  1  cluster was empty; keep the old centroid
- threshold  in  17  max allowed L1 move per centroid
- rd_addr  in  3  read index for the classification block
- rd_data  out  91  bank[rd_addr], combinational
- cent_ptr  out  3  index the next accepted new_valid is assigned to
- busy  out  1  state != IDLE
- round_done  out  1  one-cycle pulse at round end
- converged  out  1  result of the last completed round
- iter_cnt  out  8  completed rounds
- max_iter_reached  out  1  iter_cnt == max_iter

Behaviour:
- Reset (synchronous, rst_n=0 at clk edge):
  - bank all 0, state IDLE, cent_ptr 0, pipeline valids 0.
  - round_done 0, converged 0, iter_cnt 0, max_iter_reached 0.
  - Reset mid-round aborts the round and discards all partial results.
- FSM IDLE -> COLLECT -> FLUSH -> DONE -> IDLE.
- IDLE:
  - init_wr_en writes bank[init_addr]=init_data at the edge.
  - start moves to COLLECT, clears cent_ptr and the internal all_ok flag (all_ok set to 1).
  - If start and init_wr_en are both high, start wins and the init write is dropped.
  - new_valid is ignored.
- COLLECT:
  - Each new_valid is tagged with cent_ptr, then cent_ptr increments.
  - On the 8th accepted valid (cent_ptr==7), go to FLUSH.
  - start and init_wr_en are ignored.
  - Gaps between valids are allowed and have unbounded length.
- Pipeline stage 1 (edge after the valid): register the 7 per-coordinate absolute differences |new-old| as 14-bit unsigned, computed sign-extended so no overflow is possible. Also register the index, divide_by_0 and the data.
- Pipeline stage 2 (next edge):
  - dist = sum of the 7 diffs (17 bits, cannot overflow).
  - If divide_by_0: dist is treated as 0 and the bank is unchanged.
  - Otherwise: bank[idx] = new data; if dist > threshold, all_ok cleared.
- Timing:
  - FLUSH lasts exactly 1 cycle.
  - DONE lasts 1 cycle.
  - For the 8th valid in cycle N: FLUSH is cycle N+1, DONE with round_done=1 is cycle N+2, and bank and converged are updated and visible in cycle N+2.
- DONE actions:
  - converged <= all_ok, held until the next round's DONE.
  - iter_cnt increments, saturating at max_iter.
  - max_iter_reached set when iter_cnt reaches max_iter; sticky until reset.
- The comparison is against the pre-update value: stage 1 reads bank[idx] before stage 2 writes it. Indices within a round are distinct, so there is no hazard.
- rd_data reflects a bank write in the cycle after the write edge.
- dist == threshold counts as not moved (converged).

Test Plan:
- Load bank[i]=i replicated in every coordinate; start; feed 8 identical centroids, one per cycle; threshold=0 -> converged=1, round_done exactly 2 cycles after the 8th valid, iter_cnt=1.
- Same load; centroid 5 has coordinate 0 +3 and coordinate 6 -4 (dist=7); threshold=6 -> converged=0, bank[5] updated. Repeat with threshold=7 -> converged=1.
- centroid 2 has divide_by_0=1 with data 0x7FF.. in all fields -> bank[2] unchanged, converged unaffected (=1 with others equal).
- Signed edge case: old coordinate = -4096, new = +4095 -> diff 8191, dist 8191; threshold=8190 -> converged=0.
- Valids with random 0-5 cycle gaps, start and init_wr_en pulsed mid-round -> both ignored, 8 centroids stored in order, cent_ptr wraps to 0.
- rst_n=0 after the 4th valid -> all outputs and bank 0, state IDLE. Then run 100 rounds -> max_iter_reached=1, iter_cnt stays 100 on round 101.

Source files
------------

// File: rtl/convergence_check_block.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : convergence_check_block
// Brief   : Stores centroids, measures L1 movement per round, reports convergence.
// Revision: 1.0 - initial release
// ============================================================================
module convergence_check_block #(
  parameter int DATA_WIDTH   = 91,
  parameter int COORD_WIDTH  = 13,
  parameter int CENTROID_NUM = 8,
  parameter int DIST_WIDTH   = 17,
  parameter int ITER_WIDTH   = 8,
  parameter int MAX_ITER     = 100,
  parameter int IDX_WIDTH    = $clog2(CENTROID_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_wr_en,
  input  logic [IDX_WIDTH-1:0]  init_addr,
  input  logic [DATA_WIDTH-1:0] init_data,
  input  logic                  start,
  input  logic                  new_valid,
  input  logic [DATA_WIDTH-1:0] new_centroid,
  input  logic                  divide_by_0,
  input  logic [DIST_WIDTH-1:0] threshold,
  input  logic [IDX_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [IDX_WIDTH-1:0]  cent_ptr,
  output logic                  busy,
  output logic                  round_done,
  output logic                  converged,
  output logic [ITER_WIDTH-1:0] iter_cnt,
  output logic                  max_iter_reached
);

  localparam int NUM_COORD = DATA_WIDTH / COORD_WIDTH;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_FLUSH   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [IDX_WIDTH-1:0]  C_LAST_IDX = IDX_WIDTH'(CENTROID_NUM - 1);
  localparam logic [ITER_WIDTH-1:0] C_MAX_ITER = ITER_WIDTH'(MAX_ITER);

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_bank [CENTROID_NUM];
  logic                  r_all_ok;

  logic                  r_s1_valid;
  logic [IDX_WIDTH-1:0]  r_s1_idx;
  logic                  r_s1_div;
  logic [DATA_WIDTH-1:0] r_s1_data;
  logic [COORD_WIDTH:0]  r_s1_diff [NUM_COORD];

  logic [DATA_WIDTH-1:0] w_old;
  logic [COORD_WIDTH:0]  w_abs [NUM_COORD];
  logic [DIST_WIDTH-1:0] w_dist;
  logic                  w_accept;
  logic                  w_all_ok_next;
  logic [ITER_WIDTH-1:0] w_iter_next;

  assign w_old    = r_bank[cent_ptr];
  assign w_accept = (r_state == S_COLLECT) && new_valid;

  // One extra bit of sign extension keeps |new-old| exact over the full 13-bit range.
  for (genvar k = 0; k < NUM_COORD; k++) begin : g_coord
    logic [COORD_WIDTH:0] w_new_ext;
    logic [COORD_WIDTH:0] w_old_ext;
    logic [COORD_WIDTH:0] w_delta;
    assign w_new_ext = {new_centroid[k*COORD_WIDTH+COORD_WIDTH-1], new_centroid[k*COORD_WIDTH +: COORD_WIDTH]};
    assign w_old_ext = {w_old[k*COORD_WIDTH+COORD_WIDTH-1], w_old[k*COORD_WIDTH +: COORD_WIDTH]};
    assign w_delta   = w_new_ext - w_old_ext;
    assign w_abs[k]  = w_delta[COORD_WIDTH] ? (~w_delta + 1'b1) : w_delta;
  end

  always_comb begin
    w_dist = '0;
    for (int k = 0; k < NUM_COORD; k++) begin
      w_dist = w_dist + DIST_WIDTH'(r_s1_diff[k]);
    end
  end

  assign w_all_ok_next = r_all_ok & ~(r_s1_valid & ~r_s1_div & (w_dist > threshold));
  assign w_iter_next   = (iter_cnt == C_MAX_ITER) ? iter_cnt : iter_cnt + 1'b1;

  assign rd_data    = r_bank[rd_addr];
  assign busy       = (r_state != S_IDLE);
  assign round_done = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      cent_ptr         <= '0;
      r_all_ok         <= 1'b0;
      r_s1_valid       <= 1'b0;
      r_s1_idx         <= '0;
      r_s1_div         <= 1'b0;
      r_s1_data        <= '0;
      converged        <= 1'b0;
      iter_cnt         <= '0;
      max_iter_reached <= 1'b0;
      for (int k = 0; k < NUM_COORD; k++) r_s1_diff[k] <= '0;
      for (int i = 0; i < CENTROID_NUM; i++) r_bank[i] <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_idx  <= cent_ptr;
        r_s1_div  <= divide_by_0;
        r_s1_data <= new_centroid;
        for (int k = 0; k < NUM_COORD; k++) r_s1_diff[k] <= w_abs[k];
      end

      if (r_s1_valid && !r_s1_div) begin
        r_bank[r_s1_idx] <= r_s1_data;
      end
      r_all_ok <= w_all_ok_next;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_COLLECT;
            cent_ptr <= '0;
            r_all_ok <= 1'b1;
          end else if (init_wr_en) begin
            r_bank[init_addr] <= init_data;
          end
        end
        S_COLLECT: begin
          if (new_valid) begin
            cent_ptr <= cent_ptr + 1'b1;
            if (cent_ptr == C_LAST_IDX) r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          // Last stage-2 result resolves on this edge, so results appear with DONE.
          r_state          <= S_DONE;
          converged        <= w_all_ok_next;
          iter_cnt         <= w_iter_next;
          max_iter_reached <= max_iter_reached | (w_iter_next == C_MAX_ITER);
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_convergence_check_block.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_convergence_check_block
// Brief   : Randomized scenario bench against an arithmetic L1 reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_convergence_check_block;

  logic        clk = 1'b0;
  logic        rst_n, init_wr_en, start, new_valid, divide_by_0;
  logic [2:0]  init_addr, rd_addr, cent_ptr;
  logic [90:0] init_data, new_centroid, rd_data;
  logic [16:0] threshold;
  logic        busy, round_done, converged, max_iter_reached;
  logic [7:0]  iter_cnt;

  always #5 clk = ~clk;

  convergence_check_block dut (
    .clk(clk), .rst_n(rst_n), .init_wr_en(init_wr_en), .init_addr(init_addr),
    .init_data(init_data), .start(start), .new_valid(new_valid),
    .new_centroid(new_centroid), .divide_by_0(divide_by_0), .threshold(threshold),
    .rd_addr(rd_addr), .rd_data(rd_data), .cent_ptr(cent_ptr), .busy(busy),
    .round_done(round_done), .converged(converged), .iter_cnt(iter_cnt),
    .max_iter_reached(max_iter_reached)
  );

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [90:0] m_bank [8];
  int          m_iter;
  bit          m_conv, m_maxr;

  // per-round stimulus and observations
  logic [90:0] stim_c [8];
  bit          stim_dv [8];
  logic [90:0] ld [8];
  logic [2:0]  seen_ptr [8];
  logic        rd_n1, rd_n2, rd_n3, conv_n1, conv_n2, maxr_n2, busy_n1;
  logic [7:0]  iter_n2;

  function automatic logic [90:0] rep(input int v);
    logic [12:0] c;
    c = 13'(v);
    return {7{c}};
  endfunction

  function automatic int coord(input logic [90:0] v, input int k);
    logic signed [12:0] c;
    c = v[13*k +: 13];
    return int'(c);
  endfunction

  function automatic int l1(input logic [90:0] a, input logic [90:0] b);
    int s, d;
    s = 0;
    for (int k = 0; k < 7; k++) begin
      d = coord(a, k) - coord(b, k);
      s += (d < 0) ? -d : d;
    end
    return s;
  endfunction

  function automatic void model_round(input int thr);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!stim_dv[i]) begin
        if (l1(stim_c[i], m_bank[i]) > thr) ok = 1'b0;
        m_bank[i] = stim_c[i];
      end
    end
    m_conv = ok;
    if (m_iter < 100) m_iter++;
    if (m_iter == 100) m_maxr = 1'b1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_bank[i] = '0;
    m_iter = 0;
    m_conv = 1'b0;
    m_maxr = 1'b0;
  endfunction

  function automatic logic [90:0] rnd91();
    return 91'({$urandom, $urandom, $urandom});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all();
    for (int i = 0; i < 8; i++) begin
      init_wr_en = 1'b1; init_addr = 3'(i); init_data = ld[i];
      tick();
      m_bank[i] = ld[i];
    end
    init_wr_en = 1'b0;
  endtask

  task automatic drive_round(input int thr, input int max_gap, input bit poke);
    int gap;
    threshold = 17'(thr);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
        new_valid = 1'b0; new_centroid = rnd91(); divide_by_0 = 1'($urandom);
        if (poke) begin
          start = 1'($urandom); init_wr_en = 1'($urandom);
          init_addr = 3'($urandom); init_data = rnd91();
        end
        tick();
      end
      start = 1'b0; init_wr_en = 1'b0;
      seen_ptr[i] = cent_ptr;
      new_valid = 1'b1; new_centroid = stim_c[i]; divide_by_0 = stim_dv[i];
      tick();
    end
    new_valid = 1'b0; divide_by_0 = 1'b0;
    rd_n1 = round_done; conv_n1 = converged; busy_n1 = busy;
    tick();
    rd_n2 = round_done; conv_n2 = converged; iter_n2 = iter_cnt; maxr_n2 = max_iter_reached;
    tick();
    rd_n3 = round_done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; init_wr_en = 1'b0; start = 1'b0; new_valid = 1'b0; divide_by_0 = 1'b0;
    init_addr = '0; init_data = '0; new_centroid = '0; threshold = '0; rd_addr = '0;
    tick(); tick();
    model_reset();
    checks++;
    if ({busy, round_done, converged, iter_cnt, max_iter_reached, cent_ptr} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b conv=%b iter=%0d maxr=%b ptr=%0d, want all 0",
               busy, round_done, converged, iter_cnt, max_iter_reached, cent_ptr);
    end
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i); #0.5;
      checks++;
      if (rd_data !== 91'd0) begin
        errors++; $display("FAIL reset_bank[%0d]: got %h want 0", i, rd_data);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_identical();
    for (int i = 0; i < 8; i++) begin ld[i] = rep(i); stim_c[i] = rep(i); stim_dv[i] = 1'b0; end
    load_all();
    drive_round(0, 0, 1'b0);
    model_round(0);
    checks++;
    if ({rd_n1, rd_n2, rd_n3, busy_n1} !== 4'b0101) begin
      errors++; $display("FAIL identical_timing: got n1/n2/n3/busy=%b%b%b%b want 0101", rd_n1, rd_n2, rd_n3, busy_n1);
    end
    checks++;
    if (conv_n2 !== 1'b1 || conv_n2 !== m_conv) begin
      errors++; $display("FAIL identical_conv: got %b want 1", conv_n2);
    end
    checks++;
    if (iter_n2 !== 8'(m_iter)) begin
      errors++; $display("FAIL identical_iter: got %0d want %0d", iter_n2, m_iter);
    end
    checks++;
    if (busy !== 1'b0 || cent_ptr !== 3'd0) begin
      errors++; $display("FAIL identical_idle: got busy=%b ptr=%0d want 0 0", busy, cent_ptr);
    end
  endtask

  task automatic test_threshold();
    for (int t = 6; t <= 7; t++) begin
      for (int i = 0; i < 8; i++) begin ld[i] = rep(i); stim_c[i] = rep(i); stim_dv[i] = 1'b0; end
      stim_c[5][12:0]  = 13'(5 + 3);
      stim_c[5][90:78] = 13'(5 - 4);
      load_all();
      drive_round(t, 0, 1'b0);
      model_round(t);
      checks++;
      if (conv_n2 !== m_conv || conv_n2 !== (t == 7)) begin
        errors++; $display("FAIL threshold_%0d_conv: got %b want %b", t, conv_n2, m_conv);
      end
      rd_addr = 3'd5; #0.5;
      checks++;
      if (rd_data !== m_bank[5]) begin
        errors++; $display("FAIL threshold_%0d_bank5: got %h want %h", t, rd_data, m_bank[5]);
      end
    end
  endtask

  task automatic test_div0();
    for (int i = 0; i < 8; i++) begin ld[i] = rep(i); stim_c[i] = rep(i); stim_dv[i] = 1'b0; end
    stim_c[2] = '1; stim_dv[2] = 1'b1;
    load_all();
    drive_round(0, 0, 1'b0);
    model_round(0);
    checks++;
    if (conv_n2 !== m_conv) begin
      errors++; $display("FAIL div0_conv: got %b want %b", conv_n2, m_conv);
    end
    rd_addr = 3'd2; #0.5;
    checks++;
    if (rd_data !== rep(2)) begin
      errors++; $display("FAIL div0_bank2: got %h want %h", rd_data, rep(2));
    end
  endtask

  task automatic test_signed_edge();
    for (int i = 0; i < 8; i++) begin ld[i] = rep(i); stim_c[i] = rep(i); stim_dv[i] = 1'b0; end
    ld[0][12:0] = 13'h1000;
    stim_c[0][12:0] = 13'h0FFF;
    load_all();
    drive_round(8190, 0, 1'b0);
    checks++;
    if (l1(stim_c[0], m_bank[0]) != 8191) begin
      errors++; $display("FAIL signed_model_dist: got %0d want 8191", l1(stim_c[0], m_bank[0]));
    end
    model_round(8190);
    checks++;
    if (conv_n2 !== 1'b0 || conv_n2 !== m_conv) begin
      errors++; $display("FAIL signed_conv: got %b want 0", conv_n2);
    end
  endtask

  task automatic test_gaps();
    bit prev_conv;
    int thr;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) begin
        ld[i] = rnd91();
        stim_c[i] = (r[0]) ? (ld[i] ^ 91'($urandom_range(7, 0))) : rnd91();
        stim_dv[i] = ($urandom_range(5, 0) == 0);
      end
      thr = (r[0]) ? int'($urandom_range(40, 0)) : int'($urandom_range(60000, 0));
      load_all();
      prev_conv = m_conv;
      drive_round(thr, 5, 1'b1);
      model_round(thr);
      checks++;
      if (conv_n1 !== prev_conv) begin
        errors++; $display("FAIL gaps_conv_hold r%0d: got %b want %b", r, conv_n1, prev_conv);
      end
      checks++;
      if ({rd_n1, rd_n2, rd_n3} !== 3'b010 || conv_n2 !== m_conv) begin
        errors++; $display("FAIL gaps_round r%0d: got done=%b%b%b conv=%b want 010 conv=%b",
                           r, rd_n1, rd_n2, rd_n3, conv_n2, m_conv);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (seen_ptr[i] !== 3'(i)) begin
          errors++; $display("FAIL gaps_ptr r%0d[%0d]: got %0d want %0d", r, i, seen_ptr[i], i);
        end
        rd_addr = 3'(i); #0.5;
        checks++;
        if (rd_data !== m_bank[i]) begin
          errors++; $display("FAIL gaps_bank r%0d[%0d]: got %h want %h", r, i, rd_data, m_bank[i]);
        end
      end
      checks++;
      if (cent_ptr !== 3'd0) begin
        errors++; $display("FAIL gaps_ptr_wrap r%0d: got %0d want 0", r, cent_ptr);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin ld[i] = rnd91(); end
    load_all();
    threshold = 17'd0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      new_valid = 1'b1; new_centroid = rnd91(); divide_by_0 = 1'b0; tick();
    end
    rst_n = 1'b0;
    tick();
    new_valid = 1'b0;
    model_reset();
    checks++;
    if ({busy, round_done, converged, iter_cnt, max_iter_reached, cent_ptr} !== 14'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b done=%b conv=%b iter=%0d maxr=%b ptr=%0d, want all 0",
               busy, round_done, converged, iter_cnt, max_iter_reached, cent_ptr);
    end
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i); #0.5;
      checks++;
      if (rd_data !== m_bank[i]) begin
        errors++; $display("FAIL midreset_bank[%0d]: got %h want 0", i, rd_data);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_max_iter();
    int thr;
    for (int r = 1; r <= 101; r++) begin
      for (int i = 0; i < 8; i++) begin
        stim_c[i] = m_bank[i] ^ 91'($urandom_range(3, 0));
        stim_dv[i] = ($urandom_range(7, 0) == 0);
      end
      thr = int'($urandom_range(3, 0));
      drive_round(thr, 1, 1'b0);
      model_round(thr);
      checks++;
      if (iter_n2 !== 8'(m_iter) || maxr_n2 !== m_maxr || conv_n2 !== m_conv) begin
        errors++; $display("FAIL maxiter_round%0d: got iter=%0d maxr=%b conv=%b want iter=%0d maxr=%b conv=%b",
                           r, iter_n2, maxr_n2, conv_n2, m_iter, m_maxr, m_conv);
      end
    end
    checks++;
    if (iter_cnt !== 8'd100 || max_iter_reached !== 1'b1) begin
      errors++; $display("FAIL maxiter_final: got iter=%0d maxr=%b want 100 1", iter_cnt, max_iter_reached);
    end
  endtask

  initial begin
    test_reset();
    test_identical();
    test_threshold();
    test_div0();
    test_signed_edge();
    test_gaps();
    test_reset_mid();
    test_max_iter();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
